// File: rtl/mac_tx_pkg.sv
// Shared types and default sizing for the MAC TX store-and-forward frame buffer.
package mac_tx_pkg;
   localparam int unsigned DATA_W              = 64;
   localparam int unsigned EMPTY_W             = 3;
   localparam int unsigned CNT_W               = 16;
   localparam int unsigned DEF_DEPTH_LOG2      = 9;
   localparam int unsigned DEF_MAX_FRAME_WORDS = 190;

   // One buffered beat: payload plus framing flags (70 bits).
   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [EMPTY_W-1:0] empty;
      logic               sop;
      logic               eop;
      logic               err;
   } tx_word_t;

   localparam int unsigned WORD_W = $bits(tx_word_t);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FRAME   = 2'd1,
      DISCARD = 2'd2
   } wr_state_t;

   // Saturating add for the dropped-frame counter.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction
endpackage

// File: rtl/mac_tx_buf_ram.sv
// Simple dual-port frame storage with a one-cycle registered read port.
module mac_tx_buf_ram
   import mac_tx_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  tx_word_t          wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output tx_word_t          rdata
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   tx_word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/mac_tx_frame_buffer.sv
// Store-and-forward TX frame buffer between an Avalon-ST source and the MAC.
// Optional MAC_TX_ERR_DROP_EN: drop frames whose eop beat carries in_error.
module mac_tx_frame_buffer
   import mac_tx_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2      = DEF_DEPTH_LOG2,
   parameter int unsigned MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS
) (
   input  logic                 clk_156,
   input  logic                 tx_rst_n,
   input  logic                 in_startofpacket,
   input  logic                 in_endofpacket,
   input  logic                 in_valid,
   input  logic                 in_error,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [EMPTY_W-1:0]   in_empty,
   output logic                 in_ready,
   output logic                 tx_startofpacket,
   output logic                 tx_endofpacket,
   output logic                 tx_valid,
   output logic                 tx_error,
   output logic [DATA_W-1:0]    tx_data,
   output logic [EMPTY_W-1:0]   tx_empty,
   input  logic                 tx_ready,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic [DEPTH_LOG2:0]  fill_level
);
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 2**DEPTH_LOG2;

   if (MAX_FRAME_WORDS >= DEPTH) begin : g_bad_cfg
      $error("MAX_FRAME_WORDS must be smaller than 2**DEPTH_LOG2");
   end

   wr_state_t        state, state_n;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
   logic [PTR_W-1:0] cm_ptr, cm_ptr_n;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
   logic [PTR_W-1:0] frm_cnt, frm_cnt_n;
   logic [PTR_W-1:0] fill_n;
   logic [1:0]       drop_inc;
   logic             close;
   logic             accept;
   logic             we;
   logic [DEPTH_LOG2-1:0] waddr;
   tx_word_t         in_word;
   tx_word_t         rd_word;
   logic             re;
   logic             pop;
   logic [1:0]       occ;
   logic             rd_vld, pf_vld, out_vld;
   tx_word_t         pf_q, out_q;

   assign accept  = in_valid & in_ready;
   assign in_word = '{data:  in_data,
                      empty: in_empty,
                      sop:   in_startofpacket,
                      eop:   in_endofpacket,
                      err:   in_error & in_endofpacket};

   // Write-side framing: decide what gets stored, committed or rewound.
   always_comb begin
      state_n   = state;
      wr_ptr_n  = wr_ptr;
      cm_ptr_n  = cm_ptr;
      frm_cnt_n = frm_cnt;
      drop_inc  = 2'd0;
      close     = 1'b0;
      we        = 1'b0;
      waddr     = wr_ptr[DEPTH_LOG2-1:0];
      if (accept) begin
         unique case (state)
            IDLE, FRAME: begin
               if (in_startofpacket) begin
                  // In IDLE wr_ptr already equals cm_ptr, so the rewind is harmless.
                  if (state == FRAME) drop_inc = 2'd1;
                  we        = 1'b1;
                  waddr     = cm_ptr[DEPTH_LOG2-1:0];
                  wr_ptr_n  = cm_ptr + PTR_W'(1);
                  frm_cnt_n = PTR_W'(1);
                  state_n   = FRAME;
                  close     = in_endofpacket;
               end else if (state == FRAME) begin
                  if (frm_cnt == PTR_W'(MAX_FRAME_WORDS)) begin
                     wr_ptr_n = cm_ptr;
                     drop_inc = 2'd1;
                     state_n  = in_endofpacket ? IDLE : DISCARD;
                  end else begin
                     we        = 1'b1;
                     wr_ptr_n  = wr_ptr + PTR_W'(1);
                     frm_cnt_n = frm_cnt + PTR_W'(1);
                     close     = in_endofpacket;
                  end
               end
            end
            DISCARD: if (in_endofpacket) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
      if (close) begin
         state_n = IDLE;
`ifdef MAC_TX_ERR_DROP_EN
         if (in_error) begin
            wr_ptr_n = cm_ptr;
            drop_inc = drop_inc + 2'd1;
         end else begin
            cm_ptr_n = wr_ptr_n;
         end
`else
         cm_ptr_n = wr_ptr_n;
`endif
      end
   end

   // Read issue: keep RAM stage + prefetch + output holding at most two words.
   always_comb begin
      pop      = out_vld & tx_ready;
      occ      = 2'(out_vld) + 2'(pf_vld) + 2'(rd_vld) - 2'(pop);
      re       = (rd_ptr != cm_ptr) && (occ < 2'd2);
      rd_ptr_n = rd_ptr + PTR_W'(re);
      fill_n   = wr_ptr_n - rd_ptr_n;
   end

   mac_tx_buf_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk_156),
      .we    (we),
      .waddr (waddr),
      .wdata (in_word),
      .re    (re),
      .raddr (rd_ptr[DEPTH_LOG2-1:0]),
      .rdata (rd_word)
   );

   always_ff @(posedge clk_156 or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         cm_ptr     <= '0;
         rd_ptr     <= '0;
         frm_cnt    <= '0;
         drop_cnt   <= '0;
         fill_level <= '0;
         in_ready   <= 1'b0;
         rd_vld     <= 1'b0;
         pf_vld     <= 1'b0;
         out_vld    <= 1'b0;
         pf_q       <= '0;
         out_q      <= '0;
      end else begin
         state      <= state_n;
         wr_ptr     <= wr_ptr_n;
         cm_ptr     <= cm_ptr_n;
         rd_ptr     <= rd_ptr_n;
         frm_cnt    <= frm_cnt_n;
         drop_cnt   <= sat_add(drop_cnt, drop_inc);
         fill_level <= fill_n;
         in_ready   <= (fill_n != PTR_W'(DEPTH));
         rd_vld     <= re;
         // Output register refills from prefetch first to keep word order.
         if (!out_vld || pop) begin
            if (pf_vld) begin
               out_q   <= pf_q;
               out_vld <= 1'b1;
               pf_vld  <= rd_vld;
               if (rd_vld) pf_q <= rd_word;
            end else begin
               out_vld <= rd_vld;
               if (rd_vld) out_q <= rd_word;
            end
         end else if (rd_vld) begin
            pf_q   <= rd_word;
            pf_vld <= 1'b1;
         end
      end
   end

   assign tx_valid         = out_vld;
   assign tx_data          = out_q.data;
   assign tx_empty         = out_q.empty;
   assign tx_startofpacket = out_q.sop;
   assign tx_endofpacket   = out_q.eop;
   assign tx_error         = out_q.err;
endmodule

// File: tb/tb_mac_tx_frame_buffer.sv
// Self-checking bench for mac_tx_frame_buffer: frame table plus scoreboard of forwarded words.
`timescale 1ns/1ps
module tb_mac_tx_frame_buffer;
`ifdef MAC_TX_ERR_DROP_EN
   localparam bit ERR_DROP = 1'b1;
`else
   localparam bit ERR_DROP = 1'b0;
`endif

   logic        clk_156 = 1'b0;
   logic        tx_rst_n = 1'b0;
   logic        in_startofpacket = 1'b0, in_endofpacket = 1'b0, in_valid = 1'b0, in_error = 1'b0;
   logic [63:0] in_data = '0;
   logic [2:0]  in_empty = '0;
   logic        in_ready;
   logic        tx_startofpacket, tx_endofpacket, tx_valid, tx_error;
   logic [63:0] tx_data;
   logic [2:0]  tx_empty;
   logic        tx_ready = 1'b1;
   logic [15:0] drop_cnt;
   logic [9:0]  fill_level;

   mac_tx_frame_buffer dut (
      .clk_156(clk_156), .tx_rst_n(tx_rst_n),
      .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .in_valid(in_valid), .in_error(in_error), .in_data(in_data), .in_empty(in_empty),
      .in_ready(in_ready),
      .tx_startofpacket(tx_startofpacket), .tx_endofpacket(tx_endofpacket),
      .tx_valid(tx_valid), .tx_error(tx_error), .tx_data(tx_data), .tx_empty(tx_empty),
      .tx_ready(tx_ready), .drop_cnt(drop_cnt), .fill_level(fill_level)
   );

   always #5 clk_156 = ~clk_156;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  empty;
      logic        sop;
      logic        eop;
      logic        err;
   } exp_word_t;

   typedef struct {
      string      name;
      int         len;
      logic       err;
      logic [2:0] empty;
      int         exp_drops;
      int         exp_words;
   } vec_t;

   exp_word_t sb[$];
   int total = 0, bad = 0;
   int out_words = 0, frame_id = 0, exp_drop_total = 0;
   int bubbles = 0, bub_target = 0;
   bit bub_mode = 1'b0, bub_started = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output monitor: a transfer seen here completes on the next rising edge.
   always @(negedge clk_156) begin
      exp_word_t e;
      if (bub_mode && tx_rst_n && out_words < bub_target) begin
         if (tx_valid) bub_started = 1'b1;
         else if (bub_started) bubbles++;
      end
      if (tx_rst_n && tx_valid && tx_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got data %0h with nothing expected", tx_data);
         end else begin
            e = sb.pop_front();
            check("tx_data",  tx_data, e.data);
            check("tx_empty", 64'(tx_empty), 64'(e.empty));
            check("tx_sop",   64'(tx_startofpacket), 64'(e.sop));
            check("tx_eop",   64'(tx_endofpacket), 64'(e.eop));
            check("tx_error", 64'(tx_error), 64'(e.err));
         end
         out_words++;
      end
   end

   task automatic send_word(input logic sop, input logic eop, input logic err,
                            input logic [2:0] empty, input logic [63:0] data);
      int n = 0;
      in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop;
      in_error = err;  in_empty = empty;       in_data = data;
      while (1) begin
         @(negedge clk_156);
         if (in_ready) break;
         n++;
         if (n > 4000) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", n);
            break;
         end
      end
      @(posedge clk_156); #1;
      in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_error = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit with_eop, input logic err,
                             input logic [2:0] empty, input bit expect_out);
      exp_word_t fw[$];
      exp_word_t w;
      for (int i = 0; i < len; i++) begin
         w.sop   = (i == 0);
         w.eop   = with_eop && (i == len - 1);
         w.err   = w.eop & err;
         w.empty = w.eop ? empty : 3'd0;
         w.data  = {16'(frame_id), 16'(i), 32'($urandom())};
         send_word(w.sop, w.eop, w.err, w.empty, w.data);
         fw.push_back(w);
      end
      frame_id++;
      if (expect_out) foreach (fw[k]) sb.push_back(fw[k]);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || fill_level != 0 || tx_valid) && n < 3000) begin
         @(negedge clk_156);
         n++;
      end
      repeat (4) @(negedge clk_156);
      check({name, "_drained"}, 64'(n < 3000), 64'(1));
   endtask

   vec_t vecs[9];

   initial begin
      int ow;
      vecs[0] = '{"four",       4,   1'b0, 3'd3, 0, 4};
      vecs[1] = '{"single",     1,   1'b0, 3'd5, 0, 1};
      vecs[2] = '{"max_len",    190, 1'b0, 3'd0, 0, 190};
      vecs[3] = '{"over_len",   191, 1'b0, 3'd2, 1, 0};
      vecs[4] = '{"after_over", 4,   1'b0, 3'd6, 0, 4};
      vecs[5] = '{"discard",    200, 1'b0, 3'd1, 1, 0};
      vecs[6] = '{"err_multi",  5,   1'b1, 3'd4, ERR_DROP ? 1 : 0, ERR_DROP ? 0 : 5};
      vecs[7] = '{"err_single", 1,   1'b1, 3'd7, ERR_DROP ? 1 : 0, ERR_DROP ? 0 : 1};
      vecs[8] = '{"two",        2,   1'b0, 3'd0, 0, 2};

      // Reset state
      repeat (3) @(negedge clk_156);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_tx_valid", 64'(tx_valid), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      check("rst_fill",     64'(fill_level), 64'(0));
      check("rst_tx_data",  tx_data, 64'(0));
      check("rst_tx_flags", 64'({tx_startofpacket, tx_endofpacket, tx_error, tx_empty}), 64'(0));
      tx_rst_n = 1'b1;
      @(posedge clk_156); #1;
      @(negedge clk_156);
      check("post_rst_in_ready", 64'(in_ready), 64'(1));

      // Latency: tx_valid rises two edges after the eop edge
      @(posedge clk_156); #1;
      send_frame(8, 1'b1, 1'b0, 3'd5, 1'b1);
      @(negedge clk_156);
      check("lat_e0", 64'(tx_valid), 64'(0));
      @(negedge clk_156);
      check("lat_e1", 64'(tx_valid), 64'(0));
      @(negedge clk_156);
      check("lat_e2", 64'(tx_valid), 64'(1));
      wait_drain("lat");

      // Table of single frames
      foreach (vecs[v]) begin
         @(posedge clk_156); #1;
         ow = out_words;
         exp_drop_total += vecs[v].exp_drops;
         send_frame(vecs[v].len, 1'b1, vecs[v].err, vecs[v].empty, vecs[v].exp_words > 0);
         wait_drain(vecs[v].name);
         check({vecs[v].name, "_drops"}, 64'(drop_cnt), 64'(exp_drop_total));
         check({vecs[v].name, "_words"}, 64'(out_words - ow), 64'(vecs[v].exp_words));
      end

      // Stray non-sop word in IDLE is silently ignored
      @(posedge clk_156); #1;
      ow = out_words;
      send_word(1'b0, 1'b1, 1'b0, 3'd0, 64'hDEAD_BEEF_0000_0001);
      wait_drain("stray");
      check("stray_drops", 64'(drop_cnt), 64'(exp_drop_total));
      check("stray_words", 64'(out_words - ow), 64'(0));

      // New sop while a frame is open drops the open frame
      @(posedge clk_156); #1;
      ow = out_words;
      send_frame(3, 1'b0, 1'b0, 3'd0, 1'b0);
      send_frame(6, 1'b1, 1'b0, 3'd2, 1'b1);
      exp_drop_total++;
      wait_drain("restart");
      check("restart_drops", 64'(drop_cnt), 64'(exp_drop_total));
      check("restart_words", 64'(out_words - ow), 64'(6));

      // Back-to-back max frames stream without bubbles
      @(posedge clk_156); #1;
      ow = out_words;
      bub_target = out_words + 570;
      bubbles = 0; bub_started = 1'b0; bub_mode = 1'b1;
      for (int f = 0; f < 3; f++) send_frame(190, 1'b1, 1'b0, 3'd0, 1'b1);
      wait_drain("b2b");
      bub_mode = 1'b0;
      check("b2b_bubbles", 64'(bubbles), 64'(0));
      check("b2b_words",   64'(out_words - ow), 64'(570));
      check("b2b_drops",   64'(drop_cnt), 64'(exp_drop_total));

      // Fill to capacity with the MAC stalled, then drain everything
      @(posedge clk_156); #1;
      tx_ready = 1'b0;
      ow = out_words;
      fork
         for (int f = 0; f < 3; f++) send_frame(190, 1'b1, 1'b0, 3'd3, 1'b1);
         begin
            int n = 0;
            while (fill_level != 10'd512 && n < 3000) begin
               @(negedge clk_156);
               n++;
            end
            check("full_reached", 64'(fill_level), 64'(512));
            check("full_in_ready", 64'(in_ready), 64'(0));
            repeat (5) @(negedge clk_156);
            check("full_hold_in_ready", 64'(in_ready), 64'(0));
            check("full_hold_valid", 64'(tx_valid), 64'(1));
            @(posedge clk_156); #1;
            tx_ready = 1'b1;
         end
      join
      wait_drain("full");
      check("full_words", 64'(out_words - ow), 64'(570));
      check("full_drops", 64'(drop_cnt), 64'(exp_drop_total));

      // Reset with a stored frame and a partial frame discards both
      @(posedge clk_156); #1;
      tx_ready = 1'b0;
      send_frame(4, 1'b1, 1'b0, 3'd1, 1'b0);
      send_frame(3, 1'b0, 1'b0, 3'd0, 1'b0);
      @(posedge clk_156); #1;
      tx_rst_n = 1'b0;
      @(negedge clk_156);
      check("mid_rst_fill",     64'(fill_level), 64'(0));
      check("mid_rst_valid",    64'(tx_valid), 64'(0));
      check("mid_rst_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk_156); #1;
      tx_rst_n = 1'b1;
      tx_ready = 1'b1;
      exp_drop_total = 0;
      @(posedge clk_156); #1;
      ow = out_words;
      send_frame(2, 1'b1, 1'b0, 3'd4, 1'b1);
      wait_drain("post_rst");
      check("post_rst_words", 64'(out_words - ow), 64'(2));
      check("post_rst_drops", 64'(drop_cnt), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mac_tx_frame_buffer.md
MAC_TX_FRAME_BUFFER -- requirements
Module: mac_tx_frame_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, log2 of buffer depth in 64-bit words (512).
REQ-002 SHALL have parameter MAX_FRAME_WORDS, default 190, maximum accepted frame length in words (1518 B MTU); elaboration SHALL fail if MAX_FRAME_WORDS >= 2**DEPTH_LOG2.
REQ-003 SHALL provide: clk_156  in  1  sole clock, MAC TX clock domain.
REQ-004 SHALL provide: tx_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide sink: in_startofpacket, in_endofpacket, in_valid, in_error (1 each, in); in_data (in, 64); in_empty (in, 3); in_ready (out, 1).
REQ-006 SHALL provide source toward MAC: tx_startofpacket, tx_endofpacket, tx_valid, tx_error (1 each, out); tx_data (out, 64); tx_empty (out, 3); tx_ready (in, 1).
REQ-007 SHALL provide status: drop_cnt (out, 16) saturating dropped-frame count; fill_level (out, DEPTH_LOG2+1) words stored.

Function
REQ-008 Both Avalon-ST ports SHALL use readyLatency 0; a word transfers when valid and ready are both high at a rising edge.
REQ-009 SHALL be store-and-forward: no word of a frame is presented on tx_* before that frame's eop word is written.
REQ-010 SHALL keep write pointer wr_ptr, committed pointer cm_ptr and read pointer rd_ptr, each DEPTH_LOG2+1 bits, wrapping modulo 2**(DEPTH_LOG2+1).
REQ-011 in_ready SHALL be 0 when (wr_ptr - rd_ptr) == 2**DEPTH_LOG2 (full), otherwise 1.
REQ-012 Write FSM SHALL have states IDLE, FRAME and DISCARD.
REQ-013 IDLE: an accepted sop word SHALL be written and move to FRAME; an accepted non-sop word SHALL be dropped with state unchanged.
REQ-014 FRAME: an accepted eop word SHALL be written, cm_ptr SHALL become wr_ptr+1 on the same edge, and state SHALL become IDLE; sop and eop on the same word SHALL commit a one-word frame from IDLE.
REQ-015 FRAME: an accepted sop word SHALL rewind wr_ptr to cm_ptr, increment drop_cnt, and start a new frame with that word.
REQ-016 FRAME: accepting word MAX_FRAME_WORDS+1 without eop SHALL rewind wr_ptr to cm_ptr, increment drop_cnt, and enter DISCARD.
REQ-017 DISCARD: accepted words SHALL be dropped; accepted eop SHALL return to IDLE.
REQ-018 Read side SHALL present words only while rd_ptr != cm_ptr, with a registered RAM read and a prefetch stage so sustained throughput is 1 word/cycle while tx_ready is high.
REQ-019 With output empty, tx_valid SHALL rise exactly 2 cycles after the edge that accepts the eop word.
REQ-020 tx_* SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-021 Simultaneous commit and read, and simultaneous write and read at full, SHALL both proceed without loss; drop_cnt SHALL hold at 16'hFFFF.

Reset
REQ-022 On tx_rst_n low: all pointers 0, FSM IDLE, drop_cnt 0, fill_level 0, tx_valid 0, tx_startofpacket/tx_endofpacket/tx_error 0, tx_data/tx_empty 0, in_ready 0 during reset and 1 the first cycle after release.
REQ-023 Reset mid-frame SHALL discard all stored and partial frames; RAM contents need not be cleared.

Configuration
REQ-024 With MAC_TX_ERR_DROP_EN defined, an eop word with in_error=1 SHALL rewind wr_ptr to cm_ptr, increment drop_cnt, and return to IDLE with no commit.
REQ-025 Without MAC_TX_ERR_DROP_EN, such a frame SHALL be committed and forwarded with tx_error=1 on its eop word only.

Structure
REQ-026 Package mac_tx_pkg SHALL hold the stored word struct (data, empty, sop, eop, err; 70 bits), the write FSM state enum and the default DEPTH_LOG2/MAX_FRAME_WORDS constants.
REQ-027 RAM SHALL be sub-module mac_tx_buf_ram: simple dual-port, 2**DEPTH_LOG2 x 70, 1-cycle registered read.

Verification
REQ-028 Single 8-word frame, tx_ready=1 -> tx_valid rises 2 cycles after eop accepted; 8 consecutive words out, sop on word 0, eop and in_empty value on word 7.
REQ-029 Back-to-back 190-word frames, tx_ready=1 -> continuous output, no bubbles after first frame starts, drop_cnt=0.
REQ-030 Frame of 191 words -> nothing output, drop_cnt=1, following 4-word frame forwarded intact.
REQ-031 sop at word 3 of an open frame -> first frame dropped (drop_cnt=1), second frame forwarded complete.
REQ-032 tx_ready=0 while 3 x 190-word frames are offered -> in_ready=0 at fill_level=512; on tx_ready=1 all committed frames drain in order, no data lost.
REQ-033 eop with in_error=1 -> with MAC_TX_ERR_DROP_EN: not output, drop_cnt=1; without: output, tx_error=1 on eop only.
